axis_fifo: RTL

AXIS_FIFO -- requirements
Module: axis_fifo

---
 rtl/axis_pkg.sv | 24 ++
 rtl/axis_fifo_ram.sv | 26 ++
 rtl/axis_fifo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream FIFO: entry layout, release FSM
// states and the storage-width calculation.
package axis_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RELEASE = 1'b1
    } fsm_state_t;

    localparam int DEFAULT_DATA_WIDTH = 64;

    // Entry layout at the default data width; the FIFO top re-declares the
    // same field order at its own parameterised width.
    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0]   tdata;
        logic [DEFAULT_DATA_WIDTH/8-1:0] tkeep;
        logic                            tlast;
    } axis_entry_t;

    function automatic int entry_width(input int data_width);
        return data_width + data_width / 8 + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: one synchronous write port and one combinational
// read port, so the head entry is visible in the same cycle its pointer moves.
module axis_fifo_ram #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_fifo.sv
// AXI-Stream FIFO with cut-through or store-and-forward output, plus a forced
// release that drains a full FIFO holding no complete packet.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH       = 16,
    parameter bit PACKET_MODE = 1'b0
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]      s_axis_tkeep,
    input  logic                         s_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
    output logic                         overflow_release
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int EW     = entry_width(DATA_WIDTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] tdata;
        logic [KEEP_W-1:0]     tkeep;
        logic                  tlast;
    } entry_t;

    entry_t         wr_entry;
    entry_t         rd_entry;
    logic [EW-1:0]  rd_word;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  occ_q;
    logic [CW-1:0]  occ_next;
    logic [CW-1:0]  pkt_q;
    logic           ready_q;
    logic           push;
    logic           pop;
    logic           push_last;
    logic           pop_last;

    assign push      = s_axis_tvalid & ready_q;
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign push_last = push & s_axis_tlast;
    assign pop_last  = pop & rd_entry.tlast;

    assign wr_entry = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep, tlast: s_axis_tlast};
    assign rd_entry = rd_word;

    axis_fifo_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (aclk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    always_comb begin
        occ_next = occ_q;
        if (push && !pop) begin
            occ_next = occ_q + 1'b1;
        end else if (!push && pop) begin
            occ_next = occ_q - 1'b1;
        end
    end

    // tready is registered from the next occupancy so it stays low in reset
    // and rises on the first edge afterwards, without any combinational path.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ_q   <= '0;
            pkt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ_q   <= occ_next;
            ready_q <= (occ_next != FULL_COUNT);
            if (push_last && !pop_last) begin
                pkt_q <= pkt_q + 1'b1;
            end else if (!push_last && pop_last) begin
                pkt_q <= pkt_q - 1'b1;
            end
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tdata  = rd_entry.tdata;
    assign m_axis_tkeep  = rd_entry.tkeep;
    assign m_axis_tlast  = rd_entry.tlast;
    assign occupancy     = occ_q;
    assign pkt_count     = pkt_q;

    if (PACKET_MODE) begin : g_store_forward
        fsm_state_t state;
        fsm_state_t next_state;
        logic       fire_q;
        logic       release_active;

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                state  <= IDLE;
                fire_q <= 1'b0;
            end else begin
                state  <= next_state;
                fire_q <= (state == IDLE) && (next_state == RELEASE);
            end
        end

        // A full FIFO with no tlast stored can never complete a packet, so
        // output is forced open until a packet boundary or empty.
        always_comb begin
            next_state = state;
            case (state)
                IDLE:    if (occ_q == FULL_COUNT && pkt_q == '0) next_state = RELEASE;
                RELEASE: if (pop_last || occ_next == '0)         next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end

        always_comb begin
            release_active   = (state == RELEASE);
            overflow_release = fire_q;
        end

        assign m_axis_tvalid = (pkt_q != '0) || release_active;
    end else begin : g_cut_through
        assign m_axis_tvalid    = (occ_q != '0);
        assign overflow_release = 1'b0;
    end

endmodule
